// File: rtl/param_stack_pkg.sv
// Shared constants and width helpers for the parameterised LIFO stack.
package param_stack_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 256;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width needed to address entries 0..depth-1.
  function automatic int calc_iw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/param_stack_mem.sv
// Stack storage: register array with one synchronous write port and two
// combinational read ports (top and peek).
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    top_addr_i,
  output logic [WIDTH-1:0] top_data_o,
  input  logic [AW-1:0]    peek_addr_i,
  output logic [WIDTH-1:0] peek_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses past DEPTH can occur when DEPTH is not a power of two.
  assign top_data_o  = (int'(top_addr_i)  < DEPTH) ? mem_q[top_addr_i]  : '0;
  assign peek_data_o = (int'(peek_addr_i) < DEPTH) ? mem_q[peek_addr_i] : '0;

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack with peek port, push/pop replace and sticky
// overflow/underflow error flags.
module param_stack
  import param_stack_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = calc_cw(DEPTH),
  localparam int IW    = calc_iw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [IW-1:0]    peek_idx,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf
);

  logic [CW-1:0]    count_q, count_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic [IW-1:0]    cnt_lo;
  logic [IW-1:0]    top_addr, peek_addr, waddr;
  logic             we;
  logic             ovf_evt, unf_evt;
  logic [WIDTH-1:0] top_rd, peek_rd;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign peek_valid = (CW'(peek_idx) < count_q);

  // Modular IW-bit arithmetic still yields the right index when count==DEPTH.
  assign cnt_lo    = count_q[IW-1:0];
  assign top_addr  = cnt_lo - IW'(1);
  assign peek_addr = cnt_lo - IW'(1) - peek_idx;

  assign ovf_evt = push && !pop && full;
  assign unf_evt = pop && !push && empty;

  assign we    = !reset && push && (pop || !full);
  assign waddr = (push && pop && !empty) ? top_addr : cnt_lo;

  always_comb begin
    count_d = count_q;
    if (push && !pop && !full) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push && !empty) begin
      count_d = count_q - CW'(1);
    end else if (push && pop && empty) begin
      count_d = CW'(1);
    end
  end

  // A new error event outranks a simultaneous clear.
  assign err_ovf_d = ovf_evt || (err_ovf_q && !clr_err);
  assign err_unf_d = unf_evt || (err_unf_q && !clr_err);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_mem (
    .clk         (clk),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (data),
    .top_addr_i  (top_addr),
    .top_data_o  (top_rd),
    .peek_addr_i (peek_addr),
    .peek_data_o (peek_rd)
  );

  assign out       = empty      ? '0 : top_rd;
  assign peek_data = peek_valid ? peek_rd : '0;
  assign count     = count_q;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (WIDTH=16, DEPTH=4): directed scenarios
// plus randomized traffic checked against a queue-based reference model.
module tb_param_stack;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  data = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [1:0]    peek_idx = '0;
  logic [W-1:0]  out;
  logic [W-1:0]  peek_data;
  logic          peek_valid;
  logic [2:0]    count;
  logic          empty;
  logic          full;
  logic          err_ovf;
  logic          err_unf;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [D-1:0][W-1:0] ent;  // ent[i] = i-th entry below top
    int                  cnt;
    logic                ovf;
    logic                unf;
  } exp_t;

  exp_t        sb[$];
  logic [W-1:0] model[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .push       (push),
    .pop        (pop),
    .clr_err    (clr_err),
    .peek_idx   (peek_idx),
    .out        (out),
    .peek_data  (peek_data),
    .peek_valid (peek_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the reference model advances on the same edge.
  task automatic cyc(input logic r, input logic p, input logic q, input logic c,
                     input logic [W-1:0] d, input logic [1:0] pi);
    exp_t e;
    logic so, su;
    reset = r; push = p; pop = q; clr_err = c; data = d; peek_idx = pi;
    @(posedge clk);
    so = 1'b0; su = 1'b0;
    if (r) begin
      model.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p && !q) begin
        if (model.size() < D) model.push_back(d);
        else so = 1'b1;
      end else if (q && !p) begin
        if (model.size() > 0) void'(model.pop_back());
        else su = 1'b1;
      end else if (p && q) begin
        if (model.size() > 0) model[model.size()-1] = d;
        else model.push_back(d);
      end
      m_ovf = so | (m_ovf & ~c);
      m_unf = su | (m_unf & ~c);
    end
    e.cnt = model.size();
    for (int i = 0; i < D; i++)
      e.ent[i] = (i < model.size()) ? model[model.size()-1-i] : '0;
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: the DUT presents a fresh state after every edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      int pi;
      e = sb.pop_front();
      pi = int'(peek_idx);
      chk("sb_out",   int'(out),        e.cnt > 0 ? int'(e.ent[0]) : 0);
      chk("sb_count", int'(count),      e.cnt);
      chk("sb_empty", int'(empty),      e.cnt == 0 ? 1 : 0);
      chk("sb_full",  int'(full),       e.cnt == D ? 1 : 0);
      chk("sb_ovf",   int'(err_ovf),    int'(e.ovf));
      chk("sb_unf",   int'(err_unf),    int'(e.unf));
      chk("sb_pvld",  int'(peek_valid), pi < e.cnt ? 1 : 0);
      chk("sb_pdata", int'(peek_data),  pi < e.cnt ? int'(e.ent[pi]) : 0);
    end
  end

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 16'h0, 2'd0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_pvld", int'(peek_valid), 0);
    chk("rst_errs", int'({err_ovf, err_unf}), 0);

    // Basic pushes and peek
    cyc(0, 1, 0, 0, 16'h1111, 2'd0);
    cyc(0, 1, 0, 0, 16'h2222, 2'd0);
    cyc(0, 1, 0, 0, 16'h3333, 2'd2);
    chk("push_out", int'(out), 16'h3333);
    chk("push_count", int'(count), 3);
    chk("peek2_data", int'(peek_data), 16'h1111);
    chk("peek2_vld", int'(peek_valid), 1);
    cyc(0, 0, 0, 0, 16'h0, 2'd3);
    chk("peek3_data", int'(peek_data), 0);
    chk("peek3_vld", int'(peek_valid), 0);

    // Overflow, then clear
    cyc(0, 1, 0, 0, 16'h4444, 2'd0);
    cyc(0, 1, 0, 0, 16'hDEAD, 2'd0);
    chk("ovf_count", int'(count), 4);
    chk("ovf_full", int'(full), 1);
    chk("ovf_out", int'(out), 16'h4444);
    chk("ovf_flag", int'(err_ovf), 1);
    cyc(0, 0, 0, 1, 16'h0, 2'd0);
    chk("clr_ovf", int'(err_ovf), 0);
    chk("clr_count", int'(count), 4);

    // Replace while full
    cyc(0, 1, 1, 0, 16'hCCCC, 2'd1);
    chk("repf_count", int'(count), 4);
    chk("repf_full", int'(full), 1);
    chk("repf_out", int'(out), 16'hCCCC);
    chk("repf_peek", int'(peek_data), 16'h3333);
    chk("repf_ovf", int'(err_ovf), 0);

    // Set coincident with clear: set wins
    cyc(0, 1, 0, 1, 16'h7777, 2'd0);
    chk("setclr_ovf", int'(err_ovf), 1);

    // Underflow, then push+pop on empty
    cyc(1, 0, 0, 0, 16'h0, 2'd0);
    cyc(0, 0, 1, 0, 16'h0, 2'd0);
    chk("unf_count", int'(count), 0);
    chk("unf_flag", int'(err_unf), 1);
    chk("unf_out", int'(out), 0);
    cyc(0, 1, 1, 0, 16'hBEEF, 2'd0);
    chk("pp_empty_count", int'(count), 1);
    chk("pp_empty_out", int'(out), 16'hBEEF);
    chk("pp_empty_ovf", int'(err_ovf), 0);

    // Replace on partially filled stack
    cyc(1, 0, 0, 0, 16'h0, 2'd0);
    cyc(0, 1, 0, 0, 16'hAAAA, 2'd0);
    cyc(0, 1, 0, 0, 16'hBBBB, 2'd0);
    cyc(0, 1, 1, 0, 16'hCCCC, 2'd1);
    chk("rep_count", int'(count), 2);
    chk("rep_out", int'(out), 16'hCCCC);
    chk("rep_peek", int'(peek_data), 16'hAAAA);

    // Reset mid-sequence overrides push
    cyc(0, 1, 0, 0, 16'h0101, 2'd0);
    cyc(0, 1, 0, 0, 16'h0202, 2'd0);
    cyc(0, 0, 1, 0, 16'h0, 2'd0);
    cyc(0, 0, 1, 0, 16'h0, 2'd0);
    cyc(0, 0, 1, 0, 16'h0, 2'd0);
    cyc(0, 0, 1, 0, 16'h0, 2'd0);
    cyc(0, 0, 1, 0, 16'h0, 2'd0);
    cyc(0, 1, 0, 0, 16'h0303, 2'd0);
    cyc(1, 1, 0, 0, 16'h0404, 2'd0);
    chk("rstmid_count", int'(count), 0);
    chk("rstmid_empty", int'(empty), 1);
    chk("rstmid_errs", int'({err_ovf, err_unf}), 0);
    cyc(0, 1, 0, 0, 16'h5555, 2'd0);
    chk("rstmid_out", int'(out), 16'h5555);
    chk("rstmid_cnt1", int'(count), 1);

    // Randomized traffic
    for (int n = 0; n < 10000; n++) begin
      logic r, p, q, c;
      r = ($urandom_range(0, 299) == 0);
      p = ($urandom_range(0, 99) < 50);
      q = ($urandom_range(0, 99) < 42);
      c = ($urandom_range(0, 99) < 5);
      cyc(r, p, q, c, W'($urandom), 2'($urandom_range(0, 3)));
    end

    cyc(0, 0, 0, 0, 16'h0, 2'd0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 256, number of entries (>=2, need not be a power of two).
REQ-003 Derived constant CW = $clog2(DEPTH+1), width of count; IW = $clog2(DEPTH), width of peek index.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data  input  WIDTH  word to push.
REQ-007 push  input  1  push request, sampled at rising clk.
REQ-008 pop  input  1  pop request, sampled at rising clk.
REQ-009 clr_err  input  1  clears sticky error flags.
REQ-010 peek_idx  input  IW  entry offset below top (0 = top).
REQ-011 out  output  WIDTH  current top-of-stack word.
REQ-012 peek_data  output  WIDTH  word at offset peek_idx below top.
REQ-013 peek_valid  output  1  peek_idx < count.
REQ-014 count  output  CW  number of valid entries.
REQ-015 empty, full  output  1 each  count==0, count==DEPTH.
REQ-016 err_ovf, err_unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 out, peek_data, peek_valid, empty, full SHALL be combinational from registered state; new values visible in the cycle after the accepting edge (zero added latency).
REQ-018 out SHALL be 0 when empty; peek_data SHALL be 0 when peek_valid=0.
REQ-019 push=1, pop=0, !full: write data at index count, count+1.
REQ-020 push=1, pop=0, full: no write, count unchanged, err_ovf set next cycle.
REQ-021 pop=1, push=0, !empty: count-1; popped entry contents need not be cleared.
REQ-022 pop=1, push=0, empty: count stays 0, err_unf set next cycle.
REQ-023 push=1, pop=1, !empty (including full): replace top with data, count unchanged, no error.
REQ-024 push=1, pop=1, empty: behave as plain push (count becomes 1), no error.
REQ-025 count SHALL never wrap: never exceed DEPTH, never go below 0.
REQ-026 err_ovf/err_unf SHALL remain set until clr_err=1 or reset; a set event coincident with clr_err SHALL win (flag stays 1).
REQ-027 clr_err SHALL not affect count or storage.

Reset
REQ-028 reset=1 at a rising edge: count=0, err_ovf=0, err_unf=0; therefore out=0, empty=1, full=0, peek_valid=0.
REQ-029 reset SHALL override push, pop and clr_err in the same cycle; storage array contents need not be reset.
REQ-030 reset asserted mid-sequence SHALL discard all entries; first push afterwards lands at index 0.
REQ-031 Power-up without reset is undefined; bench SHALL reset before use.

Structure
REQ-032 Shared package param_stack_pkg SHALL hold a helper function for CW/IW derivation and a localparam for the default WIDTH/DEPTH.
REQ-033 Storage SHALL be a sub-module stack_mem: DEPTH x WIDTH register array, one synchronous write port, two combinational read ports (top, peek).
REQ-034 Pointer/count, flag and error logic SHALL live in param_stack; no latches, single always block for sequential state.

Verification (WIDTH=16, DEPTH=4)
REQ-035 Reset, push 0x1111,0x2222,0x3333 -> out=0x3333, count=3, peek_idx=2 gives 0x1111, peek_valid=1; peek_idx=3 gives 0, peek_valid=0.
REQ-036 Push 4 words then push 0xDEAD -> count=4, full=1, out unchanged, err_ovf=1; clr_err -> err_ovf=0.
REQ-037 From empty, pop -> count=0, err_unf=1, out=0; push+pop 0xBEEF on empty -> count=1, out=0xBEEF, no new error.
REQ-038 Stack holding 0xAAAA,0xBBBB, push+pop 0xCCCC -> count=2, out=0xCCCC, peek_idx=1 gives 0xAAAA; same when full -> count=4, full=1, err_ovf=0.
REQ-039 Push 3 words, assert reset with push=1 -> count=0, empty=1, errors 0; next push 0x5555 -> out=0x5555, count=1.
REQ-040 Random push/pop/clr_err for 10000 cycles vs. reference queue model -> out, count, flags match every cycle.
